mux_rr_n1: RTL and testbench
============================

// Module: mux_rr_n1
// PURPOSE
//   Parametrised N:1 valid-qualified data multiplexer; successor to the fixed 4:1 tree of 2:1 muxes.
//   Each input channel gets a small FIFO with a valid/ready push handshake.
//   A round-robin or fixed-priority arbiter drains the FIFOs into one registered output stage.
//   The output stage supports backpressure and tags each word with its source channel.
//   Sits between the per-lane producers and the single downstream consumer of the data path.
// PARAMETERS
//   NUM_CH    4  number of input channels, >=2
//   WIDTH     4  data width per channel, bits
//   DEPTH     4  entries per channel FIFO, power of 2, >=2
//   ARB_MODE  0  0 = round-robin, 1 = fixed priority (lowest channel index wins)
// PORTS
//   clk        in   1               single clock, all state on rising edge
//   reset      in   1               asynchronous, active-high reset
//   data_in    in   NUM_CH*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   valid_in   in   NUM_CH          per-channel push request
//   in_ready   out  NUM_CH          per-channel FIFO not full (combinational from occupancy)
//   data_out   out  WIDTH           registered output word
//   valid_out  out  1               data_out/ch_out hold a valid word
//   out_ready  in   1               downstream accepts the word this cycle
//   ch_out     out  CW              source channel of data_out; CW = $clog2(NUM_CH)
//   err_ovf    out  NUM_CH          sticky: push attempted while the channel FIFO was full
// BEHAVIOUR
//   Reset (asynchronous, asserted)
//     - All FIFOs emptied, so in_ready = all 1s.
//     - data_out = 0, valid_out = 0, ch_out = 0, err_ovf = 0.
//     - RR pointer last_grant = NUM_CH-1, so channel 0 has first priority.
//     - Reset mid-operation discards all buffered and in-flight words; nothing is emitted after release.
//   Push
//     - Channel i writes data_in[i] when valid_in[i] && in_ready[i].
//     - If valid_in[i] && !in_ready[i], the word is dropped and err_ovf[i] is set; it clears only on reset.
//     - in_ready depends on occupancy only: a full FIFO rejects a push even when it is popped the same cycle.
//   FIFO
//     - Read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH.
//     - Occupancy counter of $clog2(DEPTH)+1 bits.
//     - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
//   Output stage
//     - load = !valid_out || out_ready.
//     - When load && any FIFO is non-empty, the arbiter grants exactly one non-empty channel g.
//       Head of g -> data_out, g -> ch_out, valid_out <= 1, FIFO g popped, all at the same edge.
//     - When load && all FIFOs are empty: valid_out <= 0; data_out and ch_out hold their last value.
//     - While valid_out && !out_ready, data_out, ch_out and valid_out are held stable; no pop occurs.
//   Throughput and latency
//     - Full throughput: one word per cycle while out_ready = 1 and data is available.
//     - A word pushed at edge k into an empty system appears with valid_out = 1 after edge k+1.
//   Arbitration
//     - ARB_MODE = 0: search from (last_grant+1) mod NUM_CH upward with wrap.
//       The first non-empty channel wins; last_grant updates only on a grant.
//     - ARB_MODE = 1: lowest-index non-empty channel wins; last_grant unused.
//     - No channel is granted while its FIFO is empty, including a channel pushed in the same cycle.
//   Ordering
//     - Words from one channel leave in push order.
//     - No ordering guarantee across channels beyond the arbitration rule.
// TESTING
//   1 Single word: push 0xA on ch2 at edge k, out_ready = 1
//     -> valid_out = 1, data_out = 0xA, ch_out = 2 after edge k+1; valid_out = 0 after k+2.
//   2 RR fairness: one cycle, push 0x1/0x2/0x3/0x4 on ch0..ch3, out_ready = 1
//     -> ch_out = 0, 1, 2, 3 on 4 consecutive cycles, data 0x1..0x4.
//   3 Backpressure + full: out_ready = 0, 5 pushes on ch0
//     -> one word in the output register, 4 in the FIFO, in_ready[0] = 0.
//     6th push -> err_ovf[0] = 1, word dropped.
//     Release out_ready -> exactly 5 words in order.
//   4 Fixed priority: ARB_MODE = 1, ch0 and ch3 pushed every cycle
//     -> ch_out stays 0; ch3 is served only once ch0 stops and drains.
//   5 Wrap-around: stream 10 words 0x0..0x9 through ch1 with random out_ready
//     -> output order 0x0..0x9, no loss, no err_ovf.
//   6 Reset mid-stream: 3 words buffered on ch0/ch1, assert reset between edges
//     -> valid_out = 0 immediately, in_ready = all 1s.
//     After release, nothing is emitted until a new push arrives.

Source files
------------

// File: rtl/mux_rr_n1.sv
// mux_rr_n1: N:1 valid-qualified mux with per-channel FIFOs, RR/fixed-priority arbiter and registered output stage
module mux_rr_n1 #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*WIDTH-1:0]       data_in,
  input  logic [NUM_CH-1:0]             valid_in,
  output logic [NUM_CH-1:0]             in_ready,
  output logic [WIDTH-1:0]              data_out,
  output logic                          valid_out,
  input  logic                          out_ready,
  output logic [$clog2(NUM_CH)-1:0]     ch_out,
  output logic [NUM_CH-1:0]             err_ovf
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic [AW-1:0]    wp [NUM_CH];
  logic [AW-1:0]    rp [NUM_CH];
  logic [AW:0]      cnt [NUM_CH];
  logic [NUM_CH-1:0] ne, push, pop;
  logic [CW-1:0]    last_grant, g;
  logic             g_vld, load;
  // scanning from the highest offset down leaves the first non-empty channel in the result
  function automatic logic [CW:0] arb(input logic [NUM_CH-1:0] req, input logic [CW-1:0] lg);
    int idx;
    arb = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ARB_MODE != 0 ? k : (int'(lg) + 1 + k) % NUM_CH;
      if (req[idx[CW-1:0]]) arb = {1'b1, idx[CW-1:0]};
    end
  endfunction
  assign load = !valid_out || out_ready;
  always_comb begin
    ne = '0;
    in_ready = '0;
    push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ne[i] = cnt[i] != '0;
      in_ready[i] = cnt[i] != (AW+1)'(DEPTH);
      push[i] = valid_in[i] && in_ready[i];
    end
  end
  always_comb begin
    {g_vld, g} = arb(ne, last_grant);
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop[i] = load && g_vld && g == CW'(i);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i]) rp[i] <= rp[i] + AW'(1);
        cnt[i] <= cnt[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
        if (valid_in[i] && !in_ready[i]) err_ovf[i] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i]) mem[i][wp[i]] <= data_in[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      valid_out <= 1'b0;
      ch_out <= '0;
      last_grant <= CW'(NUM_CH - 1);
    end else if (load) begin
      valid_out <= g_vld;
      if (g_vld) begin
        data_out <= mem[g][rp[g]];
        ch_out <= g;
        last_grant <= g;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_n1.sv
// tb_mux_rr_n1: directed table plus corner-case sequences for round-robin and fixed-priority instances
module tb_mux_rr_n1;
  logic clk = 0, rst = 1;
  logic [15:0] data_in = '0;
  logic [3:0] valid_in = '0;
  logic out_ready = 0;
  logic [3:0] rr_in_ready, fp_in_ready, rr_err, fp_err, rr_data, fp_data;
  logic rr_valid, fp_valid;
  logic [1:0] rr_ch, fp_ch;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] vin; logic [15:0] din; logic ordy;
    logic ev; logic [3:0] ed; logic [1:0] ec; logic [3:0] fd; logic [1:0] fc;
  } vec_t;
  vec_t tbl[13];
  logic [3:0] q[$];
  logic [1:0] qc[$];
  always #5 clk = ~clk;
  mux_rr_n1 #(.ARB_MODE(0)) u_rr (.clk(clk), .reset(rst), .data_in(data_in), .valid_in(valid_in),
    .in_ready(rr_in_ready), .data_out(rr_data), .valid_out(rr_valid), .out_ready(out_ready),
    .ch_out(rr_ch), .err_ovf(rr_err));
  mux_rr_n1 #(.ARB_MODE(1)) u_fp (.clk(clk), .reset(rst), .data_in(data_in), .valid_in(valid_in),
    .in_ready(fp_in_ready), .data_out(fp_data), .valid_out(fp_valid), .out_ready(out_ready),
    .ch_out(fp_ch), .err_ovf(fp_err));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{4'hF, 16'h4321, 1'b1, 1'b0, 4'h0, 2'd0, 4'h0, 2'd0};
    tbl[1]  = '{4'h0, 16'h0000, 1'b1, 1'b1, 4'h1, 2'd0, 4'h1, 2'd0};
    tbl[2]  = '{4'h0, 16'h0000, 1'b1, 1'b1, 4'h2, 2'd1, 4'h2, 2'd1};
    tbl[3]  = '{4'h0, 16'h0000, 1'b1, 1'b1, 4'h3, 2'd2, 4'h3, 2'd2};
    tbl[4]  = '{4'h0, 16'h0000, 1'b1, 1'b1, 4'h4, 2'd3, 4'h4, 2'd3};
    tbl[5]  = '{4'h0, 16'h0000, 1'b1, 1'b0, 4'h4, 2'd3, 4'h4, 2'd3};
    tbl[6]  = '{4'h4, 16'h0A00, 1'b1, 1'b0, 4'h4, 2'd3, 4'h4, 2'd3};
    tbl[7]  = '{4'h0, 16'h0000, 1'b1, 1'b1, 4'hA, 2'd2, 4'hA, 2'd2};
    tbl[8]  = '{4'h0, 16'h0000, 1'b1, 1'b0, 4'hA, 2'd2, 4'hA, 2'd2};
    tbl[9]  = '{4'hA, 16'h5060, 1'b1, 1'b0, 4'hA, 2'd2, 4'hA, 2'd2};
    tbl[10] = '{4'h0, 16'h0000, 1'b1, 1'b1, 4'h5, 2'd3, 4'h6, 2'd1};
    tbl[11] = '{4'h0, 16'h0000, 1'b1, 1'b1, 4'h6, 2'd1, 4'h5, 2'd3};
    tbl[12] = '{4'h0, 16'h0000, 1'b1, 1'b0, 4'h6, 2'd1, 4'h5, 2'd3};
    repeat (2) @(negedge clk);
    chk("reset valid_out", rr_valid, 0);
    chk("reset data_out", rr_data, 0);
    chk("reset ch_out", rr_ch, 0);
    chk("reset in_ready", rr_in_ready, 4'hF);
    chk("reset err_ovf", rr_err, 0);
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      valid_in = tbl[i].vin;
      data_in = tbl[i].din;
      out_ready = tbl[i].ordy;
      cyc();
      chk($sformatf("vec%0d rr valid", i), rr_valid, tbl[i].ev);
      chk($sformatf("vec%0d rr data", i), rr_data, tbl[i].ed);
      chk($sformatf("vec%0d rr ch", i), rr_ch, tbl[i].ec);
      chk($sformatf("vec%0d fp valid", i), fp_valid, tbl[i].ev);
      chk($sformatf("vec%0d fp data", i), fp_data, tbl[i].fd);
      chk($sformatf("vec%0d fp ch", i), fp_ch, tbl[i].fc);
      chk($sformatf("vec%0d in_ready", i), rr_in_ready, 4'hF);
    end
    out_ready = 0;
    for (int j = 0; j < 5; j++) begin
      valid_in = 4'h1;
      data_in = 16'(j + 1);
      cyc();
    end
    chk("bp in_ready0", rr_in_ready[0], 0);
    chk("bp valid held", rr_valid, 1);
    chk("bp data held", rr_data, 1);
    chk("bp no err yet", rr_err, 0);
    data_in = 16'h0006;
    cyc();
    valid_in = 0;
    chk("ovf err_ovf", rr_err, 4'h1);
    chk("ovf data held", rr_data, 1);
    out_ready = 1;
    q.delete();
    repeat (10) begin
      if (rr_valid) q.push_back(rr_data);
      cyc();
    end
    chk("bp drain count", q.size(), 5);
    for (int i = 0; i < 5 && i < q.size(); i++) chk($sformatf("bp drain word%0d", i), q[i], i + 1);
    do_reset();
    for (int j = 0; j < 6; j++) begin
      valid_in = j < 4 ? 4'h9 : 4'h1;
      data_in = {4'(8 + j), 8'h00, 4'(j)};
      cyc();
      if (j >= 1) begin
        chk($sformatf("fp stream valid%0d", j), fp_valid, 1);
        chk($sformatf("fp stream ch%0d", j), fp_ch, 0);
        chk($sformatf("fp stream data%0d", j), fp_data, j - 1);
      end
    end
    valid_in = 0;
    q.delete();
    qc.delete();
    repeat (8) begin
      cyc();
      if (fp_valid) begin
        q.push_back(fp_data);
        qc.push_back(fp_ch);
      end
    end
    chk("fp drain count", q.size(), 5);
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      chk($sformatf("fp drain ch%0d", i), qc[i], i == 0 ? 0 : 3);
      chk($sformatf("fp drain data%0d", i), q[i], i == 0 ? 5 : 7 + i);
    end
    chk("fp no ovf", fp_err, 0);
    do_reset();
    #1;
    begin
      int sent = 0, cycles = 0;
      q.delete();
      qc.delete();
      while (q.size() < 10 && cycles < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        valid_in = {2'b00, sent < 10 && rr_in_ready[1], 1'b0};
        data_in = {8'h00, 4'(sent), 4'h0};
        if (rr_valid && out_ready) begin
          q.push_back(rr_data);
          qc.push_back(rr_ch);
        end
        if (valid_in[1]) sent++;
        cyc();
        cycles++;
      end
      chk("wrap count", q.size(), 10);
      for (int i = 0; i < 10 && i < q.size(); i++) begin
        chk($sformatf("wrap data%0d", i), q[i], i);
        chk($sformatf("wrap ch%0d", i), qc[i], 1);
      end
      chk("wrap no ovf", rr_err, 0);
    end
    out_ready = 0;
    valid_in = 4'h3;
    data_in = 16'h0021;
    cyc();
    valid_in = 4'h1;
    data_in = 16'h0003;
    cyc();
    valid_in = 0;
    chk("mid valid before reset", rr_valid, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid reset valid_out", rr_valid, 0);
    chk("mid reset in_ready", rr_in_ready, 4'hF);
    #2;
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("post reset idle%0d", i), rr_valid, 0);
    end
    valid_in = 4'h1;
    data_in = 16'h0007;
    cyc();
    valid_in = 0;
    chk("post reset push latency", rr_valid, 0);
    cyc();
    chk("post reset new valid", rr_valid, 1);
    chk("post reset new data", rr_data, 7);
    chk("post reset new ch", rr_ch, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
